alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue/capture controller that sits in front of the combinational 16-bit ALU. It accepts operation requests over a valid/ready handshake and holds the operands and function code stable on the ALU inputs for an op-dependent number of cycles. It then registers R, S and the ALU exception and returns them over a second valid/ready handshake. It is the datapath-side initiator for the ALU, and is used by the execute stage and by directed benches in place of free-running stimulus.

## Interface
- `WIDTH`, 16, operand/result width
- `MULDIV_LAT`, 4, cycles ALU inputs are held for MUL/DIV before capture; values below 1 are treated as 1
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request
- `req_ctl`  in  4  function code
- `req_a`, `req_b`  in  WIDTH  operands
- `alu_a`, `alu_b`  out  WIDTH  registered operands driven to the ALU
- `alu_ctl`  out  4  registered function code driven to the ALU
- `alu_r`, `alu_s`  in  WIDTH  ALU results R, S
- `alu_exc`  in  1  ALU exception
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_r`, `rsp_s`  out  WIDTH  captured results
- `rsp_exc`  out  1  captured exception or illegal-code flag
- `rsp_ctl`  out  4  function code of this response
- `exc_sticky`  out  1  accumulated exception flag (see Configuration)
- `exc_clear`  in  1  clears `exc_sticky`

## Operation
- **Legal codes:**
  - Single-cycle: ADD 1111, SUB 1110, AND 1101, OR 1100, SLL 1010, SLR 1011, ROL 1001, ROR 1000.
  - Multi-cycle: MUL 0001, DIV 0010.
  - All other codes are illegal.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, for a legal code:
    - Load `alu_a`/`alu_b`/`alu_ctl`.
    - Load the counter with L-1, where L=1 for single-cycle ops and L=MULDIV_LAT for MUL/DIV.
    - Go to EXEC.
  - On `req_valid`, for an illegal code:
    - `alu_*` unchanged.
    - `rsp_r`=`rsp_s`=0, `rsp_exc`=1, `rsp_ctl`=`req_ctl`.
    - Go to RESP.
- **EXEC:**
  - `req_ready`=0.
  - Counter decrements each cycle.
  - When the counter is 0:
    - Capture `alu_r`, `alu_s`, `alu_exc` into `rsp_r`, `rsp_s`, `rsp_exc`.
    - `rsp_ctl`=`alu_ctl`.
    - Go to RESP.
- **RESP:**
  - `rsp_valid`=1; `rsp_*` held stable.
  - On `rsp_ready`, go to IDLE.
  - `rsp_ready` is ignored in all other states.
- **Operand hold:** `alu_a`/`alu_b`/`alu_ctl` keep their last values in every state. They change only on request acceptance.
- **Result width:** results are captured verbatim. No width conversion, no exception masking.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `req_ready`=1 from the first cycle after reset.
  - `rsp_valid`=0.
  - `alu_a`/`alu_b`/`rsp_r`/`rsp_s`=0.
  - `alu_ctl`/`rsp_ctl`=0000.
  - `rsp_exc`=0, `exc_sticky`=0.
- **Latency:**
  - Accept at edge N gives `rsp_valid`=1 after edge N+L.
  - Illegal code gives `rsp_valid`=1 after edge N+1.
- **Throughput:** best case one op per L+2 cycles: accept, L EXEC cycles, response handshake. `req_ready` returns 1 the cycle after the response handshake.
- **No overlap:** a request is never accepted in the same cycle as a response handshake.
- **Reset mid-operation:** `rst` in any state returns IDLE with the reset values at the next edge. An in-flight op and an unconsumed response are discarded.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely, with all `rsp_*` and `alu_*` stable.

## Configuration
- **`ALU_STICKY_EXC_EN` defined:**
  - `exc_sticky` sets at any edge that captures `rsp_exc`=1. This includes illegal codes.
  - It clears on `exc_clear` only.
  - If a set and `exc_clear` coincide on the same edge, the set wins.
- **`ALU_STICKY_EXC_EN` undefined:**
  - `exc_sticky` is tied to 0.
  - `exc_clear` is ignored.
  - No register is inferred.

## Test plan
- **Single-cycle ADD:** ADD, A=0x0001, B=0x0001, ALU model R=A+B.
  - `rsp_valid` exactly 1 cycle after accept.
  - `rsp_r`=0x0002, `rsp_ctl`=1111, `rsp_exc`=0.
  - `req_ready`=1 one cycle after the handshake.
- **MUL latency:** MUL, A=0x7FFF, B=0x0001, MULDIV_LAT=4.
  - `alu_*` stable for 4 cycles.
  - `rsp_valid` exactly 4 cycles after accept.
  - `rsp_r`/`rsp_s` equal the ALU outputs sampled at the 4th edge.
- **Backpressure:** OR 0x00F0/0x0004 with `rsp_ready` held 0 for 3 cycles.
  - `rsp_valid` and `rsp_r` stay at 0x00F4 across all 3 cycles.
  - `req_ready`=0 throughout.
  - The handshake occurs on the 4th cycle.
- **Illegal code:** `req_ctl`=0000.
  - `rsp_valid` 1 cycle later.
  - `rsp_exc`=1, `rsp_r`=`rsp_s`=0.
  - `alu_ctl` keeps its previous value.
- **Sticky exception (`ALU_STICKY_EXC_EN`):** DIV with the ALU model driving `alu_exc`=1.
  - `exc_sticky`=1 and persists through the next ADD.
  - Cleared by `exc_clear`.
  - `exc_clear` coincident with a new exception capture leaves `exc_sticky`=1.
- **Reset mid-EXEC:** `rst` asserted during the 2nd EXEC cycle of a MUL.
  - Next cycle: `rsp_valid`=0, `alu_ctl`=0000, `req_ready`=1.
  - No response is ever emitted for the MUL.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts ALU requests, holds operands on the ALU for the op latency, captures R/S/exception.
// Optional accumulated exception flag is built when ALU_STICKY_EXC_EN is defined.
module alu_issue_ctrl #(
  parameter int WIDTH      = 16,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_ctl,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_r,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_exc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_exc,
  output logic [3:0]       rsp_ctl,
  output logic             exc_sticky,
  input  logic             exc_clear,
  output logic [1:0]       fsm_state
);

  localparam int LAT = (MULDIV_LAT < 1) ? 1 : MULDIV_LAT;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] MULDIV_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          illegal_op;
  logic          req_single;
  logic          req_muldiv;
  logic          req_legal;
  logic          capture;

  assign req_single = req_ctl[3];
  assign req_muldiv = (req_ctl == 4'b0001) || (req_ctl == 4'b0010);
  assign req_legal  = req_single | req_muldiv;
  assign capture    = (state == EXEC) && (cnt == '0);
  assign fsm_state  = state;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // req_ready is 1 only in IDLE and rsp_valid only in RESP, so the two never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctl    <= 4'b0000;
      rsp_r      <= '0;
      rsp_s      <= '0;
      rsp_exc    <= 1'b0;
      rsp_ctl    <= 4'b0000;
      cnt        <= '0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            state     <= EXEC;
            cnt       <= '0;
            if (req_legal) begin
              alu_a      <= req_a;
              alu_b      <= req_b;
              alu_ctl    <= req_ctl;
              illegal_op <= 1'b0;
              if (req_muldiv) cnt <= MULDIV_LOAD;
            end else begin
              // Illegal codes spend one EXEC cycle so their latency matches a single-cycle op.
              rsp_r      <= '0;
              rsp_s      <= '0;
              rsp_exc    <= 1'b1;
              rsp_ctl    <= req_ctl;
              illegal_op <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (capture) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            if (!illegal_op) begin
              rsp_r   <= alu_r;
              rsp_s   <= alu_s;
              rsp_exc <= alu_exc;
              rsp_ctl <= alu_ctl;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_STICKY_EXC_EN
  logic exc_set;

  // A new exception wins over a coincident clear.
  assign exc_set = ((state == IDLE) && req_valid && !req_legal) ||
                   (capture && !illegal_op && alu_exc);

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_sticky <= 1'b0;
    end else if (exc_set) begin
      exc_sticky <= 1'b1;
    end else if (exc_clear) begin
      exc_sticky <= 1'b0;
    end
  end
`else
  logic unused_exc_clear;

  assign unused_exc_clear = exc_clear;
  assign exc_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a timeline model and a bench-side ALU.
// Sticky-flag expectations follow ALU_STICKY_EXC_EN.
module tb_alu_issue_ctrl;

  localparam int W    = 16;
  localparam int MLAT = 4;
`ifdef ALU_STICKY_EXC_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_ctl;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_r;
  logic [W-1:0] alu_s;
  logic         alu_exc;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_r;
  logic [W-1:0] rsp_s;
  logic         rsp_exc;
  logic [3:0]   rsp_ctl;
  logic         exc_sticky;
  logic         exc_clear;
  logic [1:0]   unused_state;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl #(.WIDTH(W), .MULDIV_LAT(MLAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctl   (req_ctl),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctl   (alu_ctl),
    .alu_r     (alu_r),
    .alu_s     (alu_s),
    .alu_exc   (alu_exc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_s     (rsp_s),
    .rsp_exc   (rsp_exc),
    .rsp_ctl   (rsp_ctl),
    .exc_sticky(exc_sticky),
    .exc_clear (exc_clear),
    .fsm_state (unused_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench ALU: {exc, S, R} ----------------
  function automatic logic [2*W:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic [W-1:0]   s;
    logic           e;
    logic [2*W-1:0] p;
    r = '0;
    s = '0;
    e = 1'b0;
    p = a * b;
    case (c)
      4'b1111: {s[0], r} = a + b;
      4'b1110: r = a - b;
      4'b1101: r = a & b;
      4'b1100: r = a | b;
      4'b1010: r = a << b[3:0];
      4'b1011: r = a >> b[3:0];
      4'b1001: r = (a << b[3:0]) | (a >> (16 - b[3:0]));
      4'b1000: r = (a >> b[3:0]) | (a << (16 - b[3:0]));
      4'b0001: begin
        r = p[W-1:0];
        s = p[2*W-1:W];
      end
      4'b0010: begin
        if (b == '0) begin
          e = 1'b1;
          r = '1;
        end else begin
          r = a / b;
          s = a % b;
        end
      end
      default: e = 1'b0;
    endcase
    return {e, s, r};
  endfunction

  logic [2*W:0] alu_out;
  assign alu_out = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_r   = alu_out[W-1:0];
  assign alu_s   = alu_out[2*W-1:W];
  assign alu_exc = alu_out[2*W];

  // ---------------- timeline model ----------------
  function automatic logic is_muldiv(input logic [3:0] c);
    return (c == 4'b0001) || (c == 4'b0010);
  endfunction

  function automatic logic is_legal(input logic [3:0] c);
    return c[3] || is_muldiv(c);
  endfunction

  function automatic int op_lat(input logic [3:0] c);
    return is_muldiv(c) ? MLAT : 1;
  endfunction

  int           cyc = 0;        // rising edges seen so far
  int           m_due = 0;      // edge after which the response must be visible
  logic         m_started = 1'b0;
  logic         m_busy = 1'b0;
  logic [2*W:0] m_res = '0;
  logic [3:0]   m_ctl = '0;
  logic [W-1:0] m_alu_a = '0;
  logic [W-1:0] m_alu_b = '0;
  logic [3:0]   m_alu_ctl = '0;
  logic         m_sticky = 1'b0;
  logic         exp_valid;

  assign exp_valid = m_busy && (cyc >= m_due);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_started <= 1'b1;
      m_busy    <= 1'b0;
      m_alu_a   <= '0;
      m_alu_b   <= '0;
      m_alu_ctl <= '0;
      m_sticky  <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_due  <= cyc + 1 + op_lat(req_ctl);
        m_ctl  <= req_ctl;
        m_res  <= is_legal(req_ctl) ? alu_fn(req_ctl, req_a, req_b) : {1'b1, {(2*W){1'b0}}};
        if (is_legal(req_ctl)) begin
          m_alu_a   <= req_a;
          m_alu_b   <= req_b;
          m_alu_ctl <= req_ctl;
        end
      end
`ifdef ALU_STICKY_EXC_EN
      if (exc_clear) m_sticky <= 1'b0;
`endif
    end else begin
      if ((cyc + 1 > m_due) && rsp_ready) m_busy <= 1'b0;
`ifdef ALU_STICKY_EXC_EN
      if ((cyc + 1 == m_due) && m_res[2*W]) m_sticky <= 1'b1;
      else if (exc_clear) m_sticky <= 1'b0;
`endif
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started && !rst) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("alu_a", 32'(alu_a), 32'(m_alu_a));
      chk("alu_b", 32'(alu_b), 32'(m_alu_b));
      chk("alu_ctl", 32'(alu_ctl), 32'(m_alu_ctl));
      if (exp_valid) begin
        chk("rsp_r", 32'(rsp_r), 32'(m_res[W-1:0]));
        chk("rsp_s", 32'(rsp_s), 32'(m_res[2*W-1:W]));
        chk("rsp_exc", 32'(rsp_exc), 32'(m_res[2*W]));
        chk("rsp_ctl", 32'(rsp_ctl), 32'(m_ctl));
      end
      if (!m_busy || exp_valid) chk("exc_sticky", 32'(exc_sticky), 32'(m_sticky));
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    req_ctl   = c;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    exc_clear = 1'b1;
    @(posedge clk);
    #1;
    exc_clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   lat;
    logic saw_valid;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_ctl   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    exc_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("reset_rsp_r", 32'(rsp_r), 32'd0);
    chk("reset_rsp_s", 32'(rsp_s), 32'd0);
    chk("reset_rsp_ctl", 32'(rsp_ctl), 32'd0);
    chk("reset_rsp_exc", 32'(rsp_exc), 32'd0);
    chk("reset_exc_sticky", 32'(exc_sticky), 32'd0);

    send(4'b1111, 16'h0001, 16'h0001);
    wait_rsp(lat);
    chk("add_latency", 32'(lat), 32'd1);
    chk("add_r", 32'(rsp_r), 32'h0002);
    chk("add_ctl", 32'(rsp_ctl), 32'hF);
    chk("add_exc", 32'(rsp_exc), 32'd0);
    consume(0);
    chk("add_ready_after", 32'(req_ready), 32'd1);

    send(4'b0001, 16'h7FFF, 16'h0001);
    wait_rsp(lat);
    chk("mul_latency", 32'(lat), 32'd4);
    chk("mul_r", 32'(rsp_r), 32'h7FFF);
    chk("mul_s", 32'(rsp_s), 32'h0000);
    consume(0);

    send(4'b1100, 16'h00F0, 16'h0004);
    wait_rsp(lat);
    chk("or_r", 32'(rsp_r), 32'h00F4);
    consume(3);
    chk("or_ready_after", 32'(req_ready), 32'd1);

    send(4'b1110, 16'h0005, 16'h0007);
    wait_rsp(lat);
    chk("sub_r", 32'(rsp_r), 32'hFFFE);
    consume(1);
    send(4'b1010, 16'h0003, 16'h0004);
    wait_rsp(lat);
    consume(0);
    send(4'b1001, 16'h8001, 16'h0001);
    wait_rsp(lat);
    chk("rol_r", 32'(rsp_r), 32'h0003);
    consume(0);
    send(4'b1011, 16'hF000, 16'h0008);
    wait_rsp(lat);
    consume(2);
    send(4'b1101, 16'h0FF0, 16'h3C3C);
    wait_rsp(lat);
    consume(0);
    send(4'b0010, 16'd100, 16'd7);
    wait_rsp(lat);
    chk("div_latency", 32'(lat), 32'd4);
    chk("div_r", 32'(rsp_r), 32'd14);
    chk("div_s", 32'(rsp_s), 32'd2);
    consume(0);
    send(4'b1000, 16'h0001, 16'h0001);
    wait_rsp(lat);
    chk("ror_r", 32'(rsp_r), 32'h8000);
    consume(0);

    send(4'b0000, 16'h1234, 16'h5678);
    wait_rsp(lat);
    chk("ill_latency", 32'(lat), 32'd1);
    chk("ill_exc", 32'(rsp_exc), 32'd1);
    chk("ill_r", 32'(rsp_r), 32'd0);
    chk("ill_s", 32'(rsp_s), 32'd0);
    chk("ill_ctl", 32'(rsp_ctl), 32'h0);
    chk("ill_alu_ctl_kept", 32'(alu_ctl), 32'h8);
    consume(1);
    send(4'b0101, 16'hAAAA, 16'h5555);
    wait_rsp(lat);
    chk("ill2_ctl", 32'(rsp_ctl), 32'h5);
    consume(0);
    chk("ill_sets_sticky", 32'(exc_sticky), 32'(STK));

    pulse_clear();
    chk("clear_sticky", 32'(exc_sticky), 32'd0);
    send(4'b0010, 16'd10, 16'd0);
    wait_rsp(lat);
    chk("div0_exc", 32'(rsp_exc), 32'd1);
    consume(0);
    chk("div0_sticky", 32'(exc_sticky), 32'(STK));
    send(4'b1111, 16'd2, 16'd3);
    wait_rsp(lat);
    consume(0);
    chk("sticky_persists", 32'(exc_sticky), 32'(STK));
    pulse_clear();
    chk("sticky_cleared", 32'(exc_sticky), 32'd0);
    exc_clear = 1'b1;
    send(4'b0010, 16'd5, 16'd0);
    wait_rsp(lat);
    exc_clear = 1'b0;
    chk("set_beats_clear", 32'(exc_sticky), 32'(STK));
    consume(0);

    send(4'b0001, 16'd3, 16'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      saw_valid = saw_valid | rsp_valid;
    end
    chk("midrst_no_rsp", 32'(saw_valid), 32'd0);

    send(4'b1111, 16'hFFFF, 16'h0001);
    wait_rsp(lat);
    chk("add_wrap_r", 32'(rsp_r), 32'h0000);
    chk("add_wrap_s", 32'(rsp_s), 32'h0001);
    consume(0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
